inst_fetch_unit: RTL and testbench

//  Instruction fetch front end. Drives the rreq/raddr/rdata/data_valid port of the

---
 rtl/inst_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: one-outstanding-read memory port,
// redirect handling and a small PC/instruction FIFO toward decode.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter bit          WORD_ADDR = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        rreq,
  output logic [31:0] raddr,
  input  logic [31:0] rdata,
  input  logic        data_valid,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  output logic [31:0] fetch_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic [31:0]   raddr_nxt;

  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;
  logic          space;

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    return WORD_ADDR ? {2'b00, a[31:2]} : a;
  endfunction

  // a flush wins over a pop and over the completing read
  assign push = (state == REQ) && data_valid && !flush;
  assign pop  = inst_valid && inst_ready && !flush;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count + CW'(push) - CW'(pop);
  end

  assign space = count_nxt < CW'(DEPTH);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    raddr_nxt = raddr;
    unique case (state)
      IDLE: begin
        if (flush)
          pc_nxt = flush_pc;
        else if (fetch_en && space)
          state_nxt = REQ;
        raddr_nxt = map_addr(pc_nxt);
      end
      REQ: begin
        if (data_valid) begin
          pc_nxt    = flush ? flush_pc : pc + 32'd4;
          raddr_nxt = map_addr(pc_nxt);
          if (!flush && fetch_en && space)
            state_nxt = REQ;
          else
            state_nxt = IDLE;
        end else if (flush) begin
          pc_nxt    = flush_pc;
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (flush)
          pc_nxt = flush_pc;
        if (data_valid) begin
          state_nxt = IDLE;
          raddr_nxt = map_addr(pc_nxt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      raddr <= map_addr(RESET_PC);
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      raddr <= raddr_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= pc;
      q_data[wr_ptr] <= rdata;
    end
  end

  assign rreq       = (state != IDLE);
  assign inst_valid = (count != '0);
  assign inst_pc    = q_pc[rd_ptr];
  assign inst_data  = q_data[rd_ptr];
  assign fetch_pc   = pc;

  // only one read is ever outstanding, so a full FIFO never sees a push
  assert property (@(posedge clk) disable iff (!reset_n)
    !(push && count == CW'(DEPTH)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: per-cycle vector table, directed
// redirect/reset sequences and a randomized stream scoreboard.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        rreq;
  logic [31:0] raddr;
  logic [31:0] rdata = '0;
  logic        data_valid = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic [31:0] fetch_pc;

  int checks = 0;
  int errors = 0;
  int unsigned lat_lo = 0;
  int unsigned lat_hi = 0;

  inst_fetch_unit #(
    .RESET_PC (32'h0),
    .DEPTH    (4),
    .WORD_ADDR(1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fetch_en  (fetch_en),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .rreq      (rreq),
    .raddr     (raddr),
    .rdata     (rdata),
    .data_valid(data_valid),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_pc   (inst_pc),
    .inst_data (inst_data),
    .fetch_pc  (fetch_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset_n    = 1'b0;
    fetch_en   = 1'b0;
    flush      = 1'b0;
    flush_pc   = '0;
    inst_ready = 1'b0;
    step();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input int n, input string nm);
    int i;
    i = 0;
    @(negedge clk);
    while (!inst_valid && i < n) begin
      @(negedge clk);
      i++;
    end
    chk(nm, 32'(inst_valid), 32'd1);
  endtask

  // word-indexed memory, one read in flight, programmable latency
  logic        busy = 1'b0;
  logic [31:0] m_addr = '0;
  int unsigned m_cnt = 0;

  always @(posedge clk) begin
    #1;
    data_valid = 1'b0;
    if (!reset_n) begin
      busy = 1'b0;
    end else if (busy) begin
      chk("mem_rreq_hold", 32'(rreq), 32'd1);
      chk("mem_raddr_hold", raddr, m_addr);
      if (m_cnt == 0) begin
        data_valid = 1'b1;
        rdata      = word_at(m_addr);
        busy       = 1'b0;
      end else begin
        m_cnt--;
      end
    end else if (rreq) begin
      busy   = 1'b1;
      m_addr = raddr;
      m_cnt  = $urandom_range(lat_hi, lat_lo);
    end
  end

  typedef struct {
    logic        ready;
    logic        rreq;
    logic [31:0] raddr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [23];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    int pops;

    tbl[0]  = '{1'b1, 1'b0, 32'd0, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'd0, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'd0, 1'b0, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'd1, 1'b1, 32'h00};
    tbl[4]  = '{1'b1, 1'b1, 32'd1, 1'b0, 32'h00};
    tbl[5]  = '{1'b1, 1'b1, 32'd2, 1'b1, 32'h04};
    tbl[6]  = '{1'b1, 1'b1, 32'd2, 1'b0, 32'h00};
    tbl[7]  = '{1'b1, 1'b1, 32'd3, 1'b1, 32'h08};
    tbl[8]  = '{1'b1, 1'b1, 32'd3, 1'b0, 32'h00};
    tbl[9]  = '{1'b0, 1'b1, 32'd4, 1'b1, 32'h0C};
    tbl[10] = '{1'b0, 1'b1, 32'd4, 1'b1, 32'h0C};
    tbl[11] = '{1'b0, 1'b1, 32'd5, 1'b1, 32'h0C};
    tbl[12] = '{1'b0, 1'b1, 32'd5, 1'b1, 32'h0C};
    tbl[13] = '{1'b0, 1'b1, 32'd6, 1'b1, 32'h0C};
    tbl[14] = '{1'b0, 1'b1, 32'd6, 1'b1, 32'h0C};
    tbl[15] = '{1'b0, 1'b0, 32'd7, 1'b1, 32'h0C};
    tbl[16] = '{1'b0, 1'b0, 32'd7, 1'b1, 32'h0C};
    tbl[17] = '{1'b1, 1'b0, 32'd7, 1'b1, 32'h0C};
    tbl[18] = '{1'b0, 1'b1, 32'd7, 1'b1, 32'h10};
    tbl[19] = '{1'b0, 1'b1, 32'd7, 1'b1, 32'h10};
    tbl[20] = '{1'b0, 1'b0, 32'd8, 1'b1, 32'h10};
    tbl[21] = '{1'b0, 1'b0, 32'd8, 1'b1, 32'h10};
    tbl[22] = '{1'b0, 1'b0, 32'd8, 1'b1, 32'h10};

    // in-order stream, then fill the FIFO and release one slot
    lat_lo = 0;
    lat_hi = 0;
    do_reset();
    fetch_en = 1'b1;
    for (int k = 0; k < 23; k++) begin
      inst_ready = tbl[k].ready;
      @(negedge clk);
      if (k == 0)
        chk("t0_fetch_pc", fetch_pc, 32'h0);
      chk($sformatf("t%0d_rreq", k), 32'(rreq), 32'(tbl[k].rreq));
      chk($sformatf("t%0d_raddr", k), raddr, tbl[k].raddr);
      chk($sformatf("t%0d_valid", k), 32'(inst_valid), 32'(tbl[k].valid));
      if (tbl[k].valid) begin
        chk($sformatf("t%0d_pc", k), inst_pc, tbl[k].pc);
        chk($sformatf("t%0d_data", k), inst_data, word_at(tbl[k].pc >> 2));
      end
      step();
    end

    // flush two cycles into a slow read
    lat_lo = 3;
    lat_hi = 3;
    do_reset();
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    step();
    @(negedge clk);
    chk("f1_rreq_up", 32'(rreq), 32'd1);
    step();
    flush    = 1'b1;
    flush_pc = 32'h40;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("f1_drop_rreq", 32'(rreq), 32'd1);
    chk("f1_drop_raddr", raddr, 32'h0);
    chk("f1_drop_fpc", fetch_pc, 32'h40);
    step();
    step();
    step();
    @(negedge clk);
    chk("f1_idle_rreq", 32'(rreq), 32'd0);
    chk("f1_idle_raddr", raddr, 32'h10);
    chk("f1_no_stale", 32'(inst_valid), 32'd0);
    wait_valid(30, "f1_timeout");
    chk("f1_pc", inst_pc, 32'h40);
    chk("f1_data", inst_data, word_at(32'h10));

    // flush on data_valid, then two flushes while dropping
    lat_lo = 1;
    lat_hi = 1;
    do_reset();
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    step();
    step();
    step();
    flush    = 1'b1;
    flush_pc = 32'h100;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("f2_rreq", 32'(rreq), 32'd0);
    chk("f2_raddr", raddr, 32'h40);
    chk("f2_fpc", fetch_pc, 32'h100);
    chk("f2_no_stale", 32'(inst_valid), 32'd0);
    step();
    flush    = 1'b1;
    flush_pc = 32'h200;
    step();
    flush_pc = 32'h300;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("f3_drop_rreq", 32'(rreq), 32'd1);
    chk("f3_drop_raddr", raddr, 32'h40);
    chk("f3_drop_fpc", fetch_pc, 32'h300);
    step();
    @(negedge clk);
    chk("f3_idle_rreq", 32'(rreq), 32'd0);
    chk("f3_idle_raddr", raddr, 32'hC0);
    wait_valid(30, "f3_timeout");
    chk("f3_pc", inst_pc, 32'h300);
    chk("f3_data", inst_data, word_at(32'hC0));

    // fetch_en dropped while a read is in flight
    lat_lo = 2;
    lat_hi = 2;
    do_reset();
    fetch_en   = 1'b1;
    inst_ready = 1'b0;
    step();
    step();
    fetch_en = 1'b0;
    step();
    step();
    step();
    @(negedge clk);
    chk("e_rreq_off", 32'(rreq), 32'd0);
    chk("e_valid", 32'(inst_valid), 32'd1);
    chk("e_pc", inst_pc, 32'h0);
    chk("e_raddr", raddr, 32'h1);
    step();
    @(negedge clk);
    chk("e_rreq_stay", 32'(rreq), 32'd0);
    step();
    fetch_en = 1'b1;
    step();
    @(negedge clk);
    chk("e_resume_rreq", 32'(rreq), 32'd1);
    chk("e_resume_raddr", raddr, 32'h1);
    chk("e_resume_fpc", fetch_pc, 32'h4);
    step();
    inst_ready = 1'b1;
    step();
    wait_valid(30, "e_timeout");
    chk("e_next_pc", inst_pc, 32'h4);
    chk("e_next_data", inst_data, word_at(32'h1));

    // asynchronous reset in the middle of a read
    lat_lo = 1;
    lat_hi = 1;
    do_reset();
    fetch_en   = 1'b1;
    inst_ready = 1'b0;
    step();
    step();
    step();
    step();
    @(negedge clk);
    chk("r_pre_valid", 32'(inst_valid), 32'd1);
    chk("r_pre_raddr", raddr, 32'h1);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("r_rreq", 32'(rreq), 32'd0);
    chk("r_valid", 32'(inst_valid), 32'd0);
    chk("r_raddr", raddr, 32'h0);
    chk("r_fpc", fetch_pc, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("r_empty", 32'(inst_valid), 32'd0);
    wait_valid(30, "r_timeout");
    chk("r_pc", inst_pc, 32'h0);
    chk("r_data", inst_data, word_at(32'h0));

    // random traffic: after a redirect the stream is sequential from flush_pc
    lat_lo = 0;
    lat_hi = 3;
    do_reset();
    exp_pc = 32'h0;
    pops = 0;
    for (int c = 0; c < 3000; c++) begin
      fetch_en   = ($urandom_range(7) != 0);
      inst_ready = $urandom_range(1) != 0;
      flush      = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0)
        flush_pc = 32'hFFFF_FFF0;
      else
        flush_pc = $urandom() & ~32'h3;
      @(negedge clk);
      if (flush) begin
        exp_pc = flush_pc;
      end else if (inst_valid && inst_ready) begin
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_data", inst_data, word_at(exp_pc >> 2));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      step();
    end
    flush = 1'b0;
    chk("rnd_progress", 32'(pops > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
